// File: rtl/dmem_responder.sv
// Handshaked data-memory responder: one outstanding load/store, programmable latency,
// byte-strobed writes, misaligned/out-of-range accesses return resp_err with no array update.
module dmem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int          AW    = $clog2(DEPTH);
  localparam logic [32:0] LIMIT = 33'(DEPTH) * 33'd4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        lat_write;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_wstrb;

  logic        req_ready_nxt;
  logic        resp_valid_nxt;
  logic        resp_err_nxt;
  logic [31:0] resp_rdata_nxt;

  logic          accept;
  logic          access;
  logic          addr_err;
  logic [AW-1:0] idx;

  logic [31:0] mem [DEPTH];

  assign accept   = req_valid & req_ready;
  assign idx      = lat_addr[AW+1:2];
  assign addr_err = (lat_addr[1:0] != 2'b00) || ({1'b0, lat_addr} >= LIMIT);
  assign access   = (state == WAIT) && (cnt == 4'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'd0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      req_ready  <= req_ready_nxt;
      resp_valid <= resp_valid_nxt;
      resp_err   <= resp_err_nxt;
      resp_rdata <= resp_rdata_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_write <= 1'b0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
      lat_wstrb <= 4'd0;
    end else if (accept) begin
      lat_write <= req_write;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
      lat_wstrb <= req_wstrb;
    end
  end

  // Array has no reset; access is gated by the reset-cleared FSM, so a reset in WAIT drops the store.
  always_ff @(posedge clk) begin
    if (access && lat_write && !addr_err) begin
      for (int b = 0; b < 4; b++) begin
        if (lat_wstrb[b]) mem[idx][8*b +: 8] <= lat_wdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    req_ready_nxt  = req_ready;
    resp_valid_nxt = resp_valid;
    resp_err_nxt   = resp_err;
    resp_rdata_nxt = resp_rdata;
    case (state)
      IDLE: begin
        req_ready_nxt = 1'b1;
        if (accept) begin
          req_ready_nxt = 1'b0;
          cnt_nxt       = 4'(LATENCY - 1);
          state_nxt     = WAIT;
        end
      end
      WAIT: begin
        if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else begin
          state_nxt      = RESP;
          resp_valid_nxt = 1'b1;
          resp_err_nxt   = addr_err;
          resp_rdata_nxt = (addr_err || lat_write) ? 32'd0 : mem[idx];
        end
      end
      RESP: begin
        if (resp_valid && resp_ready) begin
          resp_valid_nxt = 1'b0;
          resp_err_nxt   = 1'b0;
          resp_rdata_nxt = 32'd0;
          req_ready_nxt  = 1'b1;
          state_nxt      = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed loads/stores, strobes, faults, backpressure,
// mid-operation reset and a request held while busy.
module tb_dmem_responder;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [3:0]  req_wstrb = 4'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(1024), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  logic [32:0] exp_q[$];
  int          acc_q[$];
  int          cyc = 0;
  int          prev_acc = -1;
  int          last_acc = -1;
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%09h expected 0x%09h", name, act, expv);
  endtask

  task automatic fail(input string name);
    n_chk++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  // Acceptance log: cycle index of every accepted request
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst && req_valid && req_ready) begin
      acc_q.push_back(cyc);
      prev_acc <= last_acc;
      last_acc <= cyc;
    end
  end

  logic        was_valid = 1'b0;
  logic [32:0] held = 33'd0;

  always @(negedge clk) begin
    int          a;
    logic [32:0] e;
    if (!rst) begin
      was_valid = 1'b0;
    end else if (resp_valid) begin
      if (!was_valid) begin
        if (acc_q.size() == 0) fail("latency_no_accept");
        else begin
          a = acc_q.pop_front();
          chk("latency", 33'(cyc - a - 1), 33'(LAT));
        end
      end else begin
        chk("resp_stable", {resp_err, resp_rdata}, held);
      end
      chk("req_ready_busy", {32'd0, req_ready}, 33'd0);
      held = {resp_err, resp_rdata};
      if (resp_ready) begin
        if (exp_q.size() == 0) fail("unexpected_resp");
        else begin
          e = exp_q.pop_front();
          chk("resp", {resp_err, resp_rdata}, e);
        end
      end
      was_valid = !resp_ready;
    end else begin
      was_valid = 1'b0;
    end
  end

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [32:0] e);
    int n = 0;
    exp_q.push_back(e);
    req_write = w; req_addr = a; req_wdata = d; req_wstrb = s; req_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 200);
    if (!req_ready) fail("accept_timeout");
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) fail("resp_timeout");
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    // Reset values
    #12;
    chk("rst_req_ready", {32'd0, req_ready}, 33'd0);
    chk("rst_resp_valid", {32'd0, resp_valid}, 33'd0);
    chk("rst_resp_rdata", {1'b0, resp_rdata}, 33'd0);
    chk("rst_resp_err", {32'd0, resp_err}, 33'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk("rel_req_ready", {32'd0, req_ready}, 33'd1);

    // Store then load
    issue(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, {1'b0, 32'h0});
    wait_done();
    issue(1'b0, 32'h10, 32'h0, 4'b0000, {1'b0, 32'hDEADBEEF});
    wait_done();

    // Byte strobes and empty strobe
    issue(1'b1, 32'h20, 32'h11223344, 4'b1111, {1'b0, 32'h0});
    issue(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, {1'b0, 32'h0});
    issue(1'b0, 32'h20, 32'h0, 4'b1111, {1'b0, 32'h11BB33DD});
    issue(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, {1'b0, 32'h0});
    issue(1'b0, 32'h10, 32'h0, 4'b0000, {1'b0, 32'hDEADBEEF});
    wait_done();

    // Backpressure
    resp_ready = 1'b0;
    issue(1'b0, 32'h10, 32'h0, 4'b0000, {1'b0, 32'hDEADBEEF});
    n = 0;
    while (!resp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!resp_valid) fail("bp_resp_timeout");
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1 resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_resp_valid_drop", {32'd0, resp_valid}, 33'd0);
    chk("bp_req_ready_back", {32'd0, req_ready}, 33'd1);

    // Faults and top-of-array
    issue(1'b0, 32'h22, 32'h0, 4'b0000, {1'b1, 32'h0});
    issue(1'b1, 32'h1000, 32'h55555555, 4'b1111, {1'b1, 32'h0});
    issue(1'b1, 32'h0FFC, 32'h0BADF00D, 4'b1111, {1'b0, 32'h0});
    issue(1'b0, 32'h0FFC, 32'h0, 4'b0000, {1'b0, 32'h0BADF00D});
    wait_done();

    // Reset during WAIT drops the store
    issue(1'b1, 32'h30, 32'h12345678, 4'b1111, {1'b0, 32'h0});
    wait_done();
    issue(1'b1, 32'h30, 32'hCAFEF00D, 4'b1111, {1'b0, 32'h0});
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("midrst_resp_valid", {32'd0, resp_valid}, 33'd0);
    chk("midrst_req_ready", {32'd0, req_ready}, 33'd0);
    exp_q.delete();
    acc_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_rel_ready", {32'd0, req_ready}, 33'd1);
    issue(1'b0, 32'h30, 32'h0, 4'b0000, {1'b0, 32'h12345678});
    wait_done();

    // Second request held during WAIT
    issue(1'b0, 32'h10, 32'h0, 4'b0000, {1'b0, 32'hDEADBEEF});
    issue(1'b0, 32'h20, 32'h0, 4'b0000, {1'b0, 32'h11BB33DD});
    wait_done();
    chk("busy_accept_gap", 33'(last_acc - prev_acc), 33'(LAT + 2));

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
